// File: rtl/spi_pingpong_writer_pkg.sv
// pp_pkg: shared ping-pong buffer geometry and writer FSM state encoding
package pp_pkg;
  localparam int PP_DW    = 8;
  localparam int PP_AW    = 7;
  localparam int PP_DEPTH = 2 ** PP_AW;
  localparam int PP_CNT_W = 16;
  typedef logic [1:0] pp_state_t;
  // bit 1 = holding (target bank still owned by DSP), bit 0 = target bank
  localparam logic [1:0] S_WR0   = 2'b00;
  localparam logic [1:0] S_WR1   = 2'b01;
  localparam logic [1:0] S_HOLD0 = 2'b10;
  localparam logic [1:0] S_HOLD1 = 2'b11;
endpackage

// File: rtl/spi_pingpong_writer_bank_flag.sv
// pp_bank_flag: per-bank ready/length handshake between writer and DSP
module pp_bank_flag
  import pp_pkg::*;
#(
  parameter int AW = PP_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_close,
  input  logic [AW:0] i_len,
  input  logic        i_finish,
  output logic        o_ready,
  output logic [AW:0] o_len,
  output logic        o_busy
);
  logic          r_pend;
  logic [AW:0]   r_plen;
  logic          r_ready;
  logic [AW:0]   r_len;
  // ready rises one cycle after the close so the RAM has captured the last byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_plen  <= '0;
      r_ready <= 1'b0;
      r_len   <= '0;
    end else begin
      r_pend <= i_close;
      r_plen <= i_close ? i_len : r_plen;
      if (r_pend) begin
        r_ready <= 1'b1;
        r_len   <= r_plen;
      end else if (i_finish && r_ready) begin
        r_ready <= 1'b0;
        r_len   <= '0;
      end
    end
  end
  assign o_ready = r_ready;
  assign o_len   = r_len;
  // bank is unavailable for writing if about to become ready or ready and not being released now
  assign o_busy  = r_pend | (r_ready & ~i_finish);
endmodule

// File: rtl/spi_pingpong_writer.sv
// spi_pingpong_writer: steers SPI bytes alternately into two RAM banks, drops bytes when both are held
module spi_pingpong_writer
  import pp_pkg::*;
#(
  parameter int DW    = PP_DW,
  parameter int AW    = PP_AW,
  parameter int CNT_W = PP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    rx_data,
  input  logic             rx_valid,
  input  logic             flush,
  input  logic             finish0,
  input  logic             finish1,
  output logic             wea0,
  output logic             wea1,
  output logic [AW-1:0]    addra,
  output logic [DW-1:0]    dina,
  output logic             ready0,
  output logic             ready1,
  output logic [AW:0]      len0,
  output logic [AW:0]      len1,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);
  pp_state_t        r_state;
  pp_state_t        w_next;
  logic [AW-1:0]    r_ptr;
  logic             r_wea0;
  logic             r_wea1;
  logic [AW-1:0]    r_addra;
  logic [DW-1:0]    r_dina;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_bank;
  logic             w_fill;
  logic             w_write;
  logic             w_close;
  logic             w_release;
  logic             w_drop;
  logic             w_other_busy;
  logic             w_busy0;
  logic             w_busy1;
  logic [AW:0]      w_len;
  assign w_bank       = r_state[0];
  assign w_fill       = ~r_state[1];
  assign w_write      = w_fill & rx_valid;
  assign w_close      = w_fill & ((w_write & (&r_ptr)) | (flush & ((|r_ptr) | rx_valid)));
  assign w_len        = {1'b0, r_ptr} + {{AW{1'b0}}, w_write};
  assign w_other_busy = w_bank ? w_busy0 : w_busy1;
  assign w_release    = r_state[1] & (w_bank ? (finish1 & ready1) : (finish0 & ready0));
  assign w_drop       = r_state[1] & rx_valid;
  // close hands off to the other bank; a finish on that bank in the same cycle already counts as released
  always_comb w_next = w_close ? {w_other_busy, ~w_bank} : w_release ? {1'b0, w_bank} : r_state;
  // FSM, write pointer, RAM port A registers and drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_WR0;
      r_ptr      <= '0;
      r_wea0     <= 1'b0;
      r_wea1     <= 1'b0;
      r_addra    <= '0;
      r_dina     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_ptr   <= w_close ? '0 : r_ptr + {{(AW-1){1'b0}}, w_write};
      r_wea0  <= w_write & ~w_bank;
      r_wea1  <= w_write & w_bank;
      r_addra <= w_write ? r_ptr : r_addra;
      r_dina  <= w_write ? rx_data : r_dina;
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= (&r_drop_cnt) ? r_drop_cnt : r_drop_cnt + 1'b1;
      end
    end
  end
  pp_bank_flag #(.AW(AW)) u_flag0 (
    .clk      (clk),
    .rst      (rst),
    .i_close  (w_close & ~w_bank),
    .i_len    (w_len),
    .i_finish (finish0),
    .o_ready  (ready0),
    .o_len    (len0),
    .o_busy   (w_busy0)
  );
  pp_bank_flag #(.AW(AW)) u_flag1 (
    .clk      (clk),
    .rst      (rst),
    .i_close  (w_close & w_bank),
    .i_len    (w_len),
    .i_finish (finish1),
    .o_ready  (ready1),
    .o_len    (len1),
    .o_busy   (w_busy1)
  );
  assign wea0     = r_wea0;
  assign wea1     = r_wea1;
  assign addra    = r_addra;
  assign dina     = r_dina;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_spi_pingpong_writer.sv
// tb_spi_pingpong_writer: directed stimulus, bank-level reference model and per-cycle comparison
module tb_spi_pingpong_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        flush = 1'b0;
  logic        finish0 = 1'b0;
  logic        finish1 = 1'b0;
  logic        wea0, wea1, ready0, ready1, overflow;
  logic [6:0]  addra;
  logic [7:0]  dina;
  logic [7:0]  len0, len1;
  logic [15:0] drop_cnt;
  int checks = 0;
  int errors = 0;
  int n_wea0 = 0;
  bit go = 0;

  spi_pingpong_writer dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .flush(flush),
    .finish0(finish0), .finish1(finish1), .wea0(wea0), .wea1(wea1), .addra(addra),
    .dina(dina), .ready0(ready0), .ready1(ready1), .len0(len0), .len1(len1),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: banks as owned-by-writer / owned-by-DSP, byte counts and a drop tally
  bit [1:0] m_wea, m_rdy;
  int m_len[2];
  int m_due[2];
  int m_fill, m_tgt, m_addr, m_din, m_drop;
  bit m_wait, m_ovf;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_wea = 0; m_rdy = 0; m_len = '{0, 0}; m_due = '{0, 0};
      m_fill = 0; m_tgt = 0; m_addr = 0; m_din = 0; m_drop = 0; m_wait = 0; m_ovf = 0;
    end else begin
      automatic bit [1:0] fin = {finish1, finish0};
      automatic bit [1:0] was_rdy = m_rdy;
      automatic int was_due[2] = m_due;
      m_wea = 0;
      for (int b = 0; b < 2; b++) begin
        if (fin[b] && was_rdy[b]) begin m_rdy[b] = 0; m_len[b] = 0; end
        if (was_due[b] != 0) begin m_rdy[b] = 1; m_len[b] = was_due[b]; end
        m_due[b] = 0;
      end
      if (m_wait) begin
        if (rx_valid) begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
        if (fin[m_tgt] && was_rdy[m_tgt]) m_wait = 0;
      end else begin
        if (rx_valid) begin
          m_wea[m_tgt] = 1; m_addr = m_fill; m_din = rx_data; m_fill++;
        end
        if (m_fill == 128 || (flush && m_fill > 0)) begin
          automatic int nt = 1 - m_tgt;
          m_due[m_tgt] = m_fill;
          m_fill = 0;
          m_wait = (was_rdy[nt] && !fin[nt]) || was_due[nt] != 0;
          m_tgt = nt;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (go) begin
      chk("wea0", wea0, m_wea[0]);
      chk("wea1", wea1, m_wea[1]);
      chk("addra", addra, m_addr);
      chk("dina", dina, m_din);
      chk("ready0", ready0, m_rdy[0]);
      chk("ready1", ready1, m_rdy[1]);
      chk("len0", len0, m_len[0]);
      chk("len1", len1, m_len[1]);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("wea_excl", wea0 & wea1, 0);
      if (wea0) n_wea0++;
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic fl, input logic f0, input logic f1);
    rx_valid = v; rx_data = d; flush = fl; finish0 = f0; finish1 = f1;
    @(posedge clk); #1;
    rx_valid = 0; rx_data = '0; flush = 0; finish0 = 0; finish1 = 0;
  endtask

  task automatic send(input logic [7:0] d);
    drive(1, d, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1; idle(2); rst = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    go = 1;
    do_reset();
    chk("rst_wea0", wea0, 0);
    chk("rst_ready0", ready0, 0);
    chk("rst_len1", len1, 0);
    chk("rst_drop", drop_cnt, 0);
    // Full bank 0 then first byte to bank 1
    n_wea0 = 0;
    for (int i = 0; i < 128; i++) send(8'(i));
    chk("last_addr", addra, 127);
    chk("ready0_early", ready0, 0);
    idle(1);
    chk("wea0_pulses", n_wea0, 128);
    chk("full_ready0", ready0, 1);
    chk("full_len0", len0, 128);
    send(8'h80);
    chk("next_wea1", wea1, 1);
    chk("next_addr", addra, 0);
    chk("next_dina", dina, 8'h80);
    // Fill bank 1, then both held: drops
    for (int i = 1; i < 128; i++) send(8'(8'h80 + i));
    idle(1);
    chk("full_ready1", ready1, 1);
    for (int i = 0; i < 3; i++) send(8'hA0);
    chk("hold_ovf", overflow, 1);
    chk("hold_drop", drop_cnt, 3);
    drive(0, 0, 0, 1, 0);
    chk("fin0_ready0", ready0, 0);
    send(8'h55);
    chk("after_fin_wea0", wea0, 1);
    chk("after_fin_addr", addra, 0);
    idle(2);
    // Flush after five bytes, and a flush at pointer zero
    do_reset();
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("flush_ready0", ready0, 1);
    chk("flush_len0", len0, 5);
    idle(1);
    send(8'h77);
    chk("flush_next_wea1", wea1, 1);
    chk("flush_next_addr", addra, 0);
    idle(2);
    // Flush together with the sixth byte; stray finish1
    do_reset();
    for (int i = 0; i < 5; i++) send(8'(8'h20 + i));
    drive(1, 8'h25, 1, 0, 0);
    chk("flush6_addr", addra, 5);
    idle(1);
    chk("flush6_len0", len0, 6);
    drive(0, 0, 0, 0, 1);
    chk("stray_fin1_ready1", ready1, 0);
    idle(2);
    // Reset mid-fill of bank 1 with bank 0 ready
    do_reset();
    for (int i = 0; i < 168; i++) send(8'(i));
    chk("pre_rst_ready0", ready0, 1);
    rst = 1; idle(1); rst = 0;
    chk("mid_rst_ready0", ready0, 0);
    chk("mid_rst_len0", len0, 0);
    chk("mid_rst_addr", addra, 0);
    send(8'h99);
    chk("mid_rst_wea0", wea0, 1);
    chk("mid_rst_next_addr", addra, 0);
    idle(2);
    // Close bank 0 in the same cycle bank 1 is finished
    do_reset();
    for (int i = 0; i < 3; i++) send(8'(8'h30 + i));
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) send(8'(8'h40 + i));
    drive(0, 0, 1, 0, 0);
    idle(1);
    drive(0, 0, 0, 1, 0);
    send(8'h50);
    send(8'h51);
    drive(1, 8'h52, 1, 0, 1);
    chk("race_ready1", ready1, 0);
    idle(1);
    chk("race_len0", len0, 3);
    send(8'h60);
    chk("race_wea1", wea1, 1);
    chk("race_addr", addra, 0);
    chk("race_drop", drop_cnt, 0);
    idle(2);
    go = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
